// File: rtl/prim_onehot_mux_fifo.sv
// rtl/prim_onehot_mux_fifo.sv - one-hot channel select feeding a small registered output FIFO
//
// Selects one of Inputs valid/ready channels with a one-hot select and queues the chosen
// word, tagged with its source channel index, into a Depth-entry FIFO.
// Multi-hot selects block every channel and raise err_o.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   in_i         per-channel data (unpacked [Inputs])
//   in_valid_i   per-channel valid
//   in_ready_o   per-channel ready (selected, legal select, FIFO not full)
//   sel_i        channel select, one-hot or zero
//   out_o        FIFO head data
//   out_idx_o    source channel of the head word
//   out_valid_o  FIFO non-empty
//   out_ready_i  consumer accepts the head word
//   err_o        multi-hot select seen (sticky or pulse, see StickyErr)
//   err_clr_i    clears a sticky err_o
module prim_onehot_mux_fifo #(
    parameter int Width     = 32,
    parameter int Inputs    = 8,
    parameter int Depth     = 2,
    parameter int StickyErr = 1,
    localparam int IdxW     = (Inputs > 1) ? $clog2(Inputs) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [Width-1:0]  in_i [Inputs],
    input  logic [Inputs-1:0] in_valid_i,
    output logic [Inputs-1:0] in_ready_o,
    input  logic [Inputs-1:0] sel_i,
    output logic [Width-1:0]  out_o,
    output logic [IdxW-1:0]   out_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              err_o,
    input  logic              err_clr_i
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic              legal;
    logic              multi;
    logic              full;
    logic              push;
    logic              pop;
    logic [Width-1:0]  mux_data;
    logic [IdxW-1:0]   mux_idx;

    logic [Width-1:0]  mem_data [Depth];
    logic [IdxW-1:0]   mem_idx  [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;

    // Copy of the most recently popped entry, shown on the outputs while empty.
    logic [Width-1:0]  last_data;
    logic [IdxW-1:0]   last_idx;

    // Explicit wrap so that non-power-of-2 depths cycle through 0..Depth-1 only.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign legal = $onehot(sel_i);
    assign multi = (|sel_i) & ~legal;
    assign full  = (count == CntW'(Depth));

    // Readiness depends only on registered occupancy: no path from out_ready_i.
    assign in_ready_o = sel_i & {Inputs{legal & ~full}};
    assign push       = |(in_valid_i & in_ready_o);

    assign out_valid_o = (count != '0);
    assign pop         = out_valid_o & out_ready_i;

    // AND/OR mux and index encoder; only meaningful when the select is legal.
    always_comb begin
        mux_data = '0;
        mux_idx  = '0;
        for (int i = 0; i < Inputs; i++) begin
            mux_data = mux_data | (in_i[i] & {Width{sel_i[i]}});
            if (sel_i[i]) begin
                mux_idx = mux_idx | IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
            last_idx  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= mux_data;
                mem_idx[wr_ptr]  <= mux_idx;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                last_data <= mem_data[rd_ptr];
                last_idx  <= mem_idx[rd_ptr];
                rd_ptr    <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (!push && pop) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (StickyErr != 0) begin
            // A new event wins over a simultaneous clear.
            err_o <= multi | (err_o & ~err_clr_i);
        end else begin
            err_o <= multi;
        end
    end

    assign out_o     = out_valid_o ? mem_data[rd_ptr] : last_data;
    assign out_idx_o = out_valid_o ? mem_idx[rd_ptr]  : last_idx;

endmodule

// File: tb/tb_prim_onehot_mux_fifo.sv
// tb/tb_prim_onehot_mux_fifo.sv - directed and scoreboard bench for prim_onehot_mux_fifo
module tb_prim_onehot_mux_fifo;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    // Instance A: Inputs=8, Depth=2, sticky error
    logic [31:0] a_in [8];
    logic [7:0]  a_valid, a_ready, a_sel;
    logic [31:0] a_out;
    logic [2:0]  a_idx;
    logic        a_ov, a_or, a_err, a_clr;

    // Instance B: Inputs=3, Depth=3, pulse error
    logic [31:0] b_in [3];
    logic [2:0]  b_valid, b_ready, b_sel;
    logic [31:0] b_out;
    logic [1:0]  b_idx;
    logic        b_ov, b_or, b_err, b_clr;

    // Instance C: Inputs=1, Depth=1
    logic [31:0] c_in [1];
    logic [0:0]  c_valid, c_ready, c_sel;
    logic [31:0] c_out;
    logic [0:0]  c_idx;
    logic        c_ov, c_or, c_err, c_clr;

    prim_onehot_mux_fifo #(.Width(32), .Inputs(8), .Depth(2), .StickyErr(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_i(a_in), .in_valid_i(a_valid), .in_ready_o(a_ready),
        .sel_i(a_sel), .out_o(a_out), .out_idx_o(a_idx), .out_valid_o(a_ov),
        .out_ready_i(a_or), .err_o(a_err), .err_clr_i(a_clr)
    );

    prim_onehot_mux_fifo #(.Width(32), .Inputs(3), .Depth(3), .StickyErr(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_i(b_in), .in_valid_i(b_valid), .in_ready_o(b_ready),
        .sel_i(b_sel), .out_o(b_out), .out_idx_o(b_idx), .out_valid_o(b_ov),
        .out_ready_i(b_or), .err_o(b_err), .err_clr_i(b_clr)
    );

    prim_onehot_mux_fifo #(.Width(32), .Inputs(1), .Depth(1), .StickyErr(1)) dut_c (
        .clk_i(clk), .rst_i(rst), .in_i(c_in), .in_valid_i(c_valid), .in_ready_o(c_ready),
        .sel_i(c_sel), .out_o(c_out), .out_idx_o(c_idx), .out_valid_o(c_ov),
        .out_ready_i(c_or), .err_o(c_err), .err_clr_i(c_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_all();
        for (int i = 0; i < 8; i++) a_in[i] = 32'h0;
        for (int i = 0; i < 3; i++) b_in[i] = 32'h0;
        c_in[0] = 32'h0;
        a_valid = '0; a_sel = '0; a_or = 1'b0; a_clr = 1'b0;
        b_valid = '0; b_sel = '0; b_or = 1'b0; b_clr = 1'b0;
        c_valid = '0; c_sel = '0; c_or = 1'b0; c_clr = 1'b0;
    endtask

    task automatic drain_all();
        @(negedge clk);
        idle_all();
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        repeat (4) @(negedge clk);
        a_or = 1'b0; b_or = 1'b0; c_or = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", a_ov); end
        n_vec++; if (a_out !== 32'h0) begin n_err++; $display("FAIL reset_a_out: got %h want 0", a_out); end
        n_vec++; if (a_idx !== 3'd0) begin n_err++; $display("FAIL reset_a_idx: got %0d want 0", a_idx); end
        n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_a_err: got %b want 0", a_err); end
        n_vec++; if (b_ov !== 1'b0 || b_out !== 32'h0 || b_err !== 1'b0) begin
            n_err++; $display("FAIL reset_b: got valid=%b out=%h err=%b want 0/0/0", b_ov, b_out, b_err); end
        n_vec++; if (c_ov !== 1'b0 || c_out !== 32'h0 || c_err !== 1'b0) begin
            n_err++; $display("FAIL reset_c: got valid=%b out=%h err=%b want 0/0/0", c_ov, c_out, c_err); end
        rst = 1'b0;
    endtask

    task automatic test_single_push();
        @(negedge clk);
        a_sel = 8'h04; a_valid = 8'h04; a_in[2] = 32'hDEAD_BEEF; a_or = 1'b1;
        #1;
        n_vec++; if (a_ready !== 8'h04) begin n_err++; $display("FAIL single_ready: got %h want 04", a_ready); end
        n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL single_latency: got valid=%b want 0", a_ov); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_vec++; if (a_ov !== 1'b1 || a_out !== 32'hDEAD_BEEF + 32'(k - 1) || a_idx !== 3'd2) begin
                n_err++; $display("FAIL single_stream%0d: got v=%b d=%h i=%0d want 1/%h/2",
                                  k, a_ov, a_out, a_idx, 32'hDEAD_BEEF + 32'(k - 1)); end
            a_in[2] = 32'hDEAD_BEEF + 32'(k);
        end
        @(negedge clk);
        a_valid = 8'h00;
        #1;
        n_vec++; if (a_out !== 32'hDEAD_BEEF + 32'd3) begin n_err++; $display("FAIL single_last: got %h want %h", a_out, 32'hDEAD_BEEF + 32'd3); end
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL single_empty: got valid=%b want 0", a_ov); end
        idle_all();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_or = 1'b0; a_sel = 8'h04; a_valid = 8'h04; a_in[2] = 32'h1000_0000;
        #1;
        n_vec++; if (a_ready[2] !== 1'b1) begin n_err++; $display("FAIL bp_ready0: got %b want 1", a_ready[2]); end
        @(negedge clk);
        a_in[2] = 32'h1000_0001;
        #1;
        n_vec++; if (a_ready[2] !== 1'b1 || a_out !== 32'h1000_0000) begin
            n_err++; $display("FAIL bp_second: got ready=%b out=%h want 1/10000000", a_ready[2], a_out); end
        @(negedge clk);
        a_in[2] = 32'h1000_0002;
        #1;
        n_vec++; if (a_ready[2] !== 1'b0 || a_out !== 32'h1000_0000) begin
            n_err++; $display("FAIL bp_full: got ready=%b out=%h want 0/10000000", a_ready[2], a_out); end
        @(negedge clk);
        a_valid = 8'h00; a_or = 1'b1;
        #1;
        n_vec++; if (a_ready[2] !== 1'b0 || a_out !== 32'h1000_0000) begin
            n_err++; $display("FAIL bp_full_pop: got ready=%b out=%h want 0/10000000", a_ready[2], a_out); end
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b1 || a_out !== 32'h1000_0001) begin
            n_err++; $display("FAIL bp_pop2: got v=%b out=%h want 1/10000001", a_ov, a_out); end
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL bp_third_dropped: got valid=%b want 0", a_ov); end
        idle_all();
    endtask

    task automatic test_wrap_stream();
        logic [31:0] qd[$];
        int          qi[$];
        int          sent, got, ch;
        logic [7:0]  exp_ready;
        sent = 0; got = 0; ch = 0;
        for (int cyc = 0; cyc < 1000 && !(sent == 100 && qd.size() == 0); cyc++) begin
            @(negedge clk);
            #1;
            n_vec++; if (a_ov !== (qd.size() > 0)) begin n_err++; $display("FAIL wrap_valid: got %b want %b", a_ov, qd.size() > 0); end
            if (qd.size() > 0) begin
                n_vec++; if (a_out !== qd[0] || a_idx !== 3'(qi[0])) begin
                    n_err++; $display("FAIL wrap_head: got %h/%0d want %h/%0d", a_out, a_idx, qd[0], qi[0]); end
            end
            for (int i = 0; i < 8; i++) a_in[i] = $urandom;
            if (sent < 100) begin
                ch = sent % 8;
                a_sel = 8'(1 << ch);
                a_valid = ($urandom % 4 != 0) ? 8'(1 << ch) : 8'h00;
                a_in[ch] = 32'hA500_0000 + 32'(sent);
            end else begin
                a_sel = 8'h00; a_valid = 8'h00;
            end
            a_or = ($urandom % 3 != 0);
            #1;
            exp_ready = (qd.size() < 2) ? a_sel : 8'h00;
            n_vec++; if (a_ready !== exp_ready) begin n_err++; $display("FAIL wrap_ready: got %h want %h", a_ready, exp_ready); end
            if (qd.size() > 0 && a_or) begin
                void'(qd.pop_front()); void'(qi.pop_front()); got++;
            end
            if (|(a_valid & exp_ready)) begin
                qd.push_back(32'hA500_0000 + 32'(sent)); qi.push_back(ch); sent++;
            end
        end
        n_vec++; if (got != 100) begin n_err++; $display("FAIL wrap_count: got %0d words want 100", got); end
        idle_all();
    endtask

    task automatic test_multi_hot();
        @(negedge clk);
        a_sel = 8'h11; a_valid = 8'hFF; a_or = 1'b0; a_clr = 1'b0;
        #1;
        n_vec++; if (a_ready !== 8'h00 || a_err !== 1'b0) begin
            n_err++; $display("FAIL multi_block: got ready=%h err=%b want 00/0", a_ready, a_err); end
        @(negedge clk);
        #1;
        n_vec++; if (a_err !== 1'b1 || a_ov !== 1'b0) begin
            n_err++; $display("FAIL multi_err: got err=%b valid=%b want 1/0", a_err, a_ov); end
        a_clr = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (a_err !== 1'b1) begin n_err++; $display("FAIL multi_clr_collide: got %b want 1", a_err); end
        a_sel = 8'h00;
        @(negedge clk);
        #1;
        n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL multi_clr: got %b want 0", a_err); end
        idle_all();
    endtask

    task automatic test_zero_sel();
        @(negedge clk);
        a_sel = 8'h01; a_valid = 8'h01; a_in[0] = 32'h5A5A_0001; a_or = 1'b0;
        @(negedge clk);
        a_sel = 8'h00; a_valid = 8'hFF;
        for (int i = 0; i < 8; i++) a_in[i] = 32'hFFFF_0000 + 32'(i);
        #1;
        n_vec++; if (a_ready !== 8'h00 || a_ov !== 1'b1 || a_out !== 32'h5A5A_0001) begin
            n_err++; $display("FAIL zero_sel_ready: got ready=%h v=%b out=%h want 00/1/5a5a0001", a_ready, a_ov, a_out); end
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b1 || a_out !== 32'h5A5A_0001 || a_idx !== 3'd0 || a_err !== 1'b0) begin
            n_err++; $display("FAIL zero_sel_hold: got v=%b out=%h i=%0d err=%b want 1/5a5a0001/0/0", a_ov, a_out, a_idx, a_err); end
        a_valid = 8'h00; a_or = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL zero_sel_drain: got valid=%b want 0", a_ov); end
        idle_all();
    endtask

    task automatic test_err_pulse_b();
        @(negedge clk);
        b_sel = 3'b101; b_valid = 3'b111;
        #1;
        n_vec++; if (b_ready !== 3'b000) begin n_err++; $display("FAIL pulse_ready: got %b want 000", b_ready); end
        @(negedge clk);
        #1;
        n_vec++; if (b_err !== 1'b1) begin n_err++; $display("FAIL pulse_set: got %b want 1", b_err); end
        b_sel = 3'b000;
        @(negedge clk);
        #1;
        n_vec++; if (b_err !== 1'b0) begin n_err++; $display("FAIL pulse_fall: got %b want 0", b_err); end
        b_sel = 3'b011; b_clr = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (b_err !== 1'b1 || b_ov !== 1'b0) begin
            n_err++; $display("FAIL pulse_clr_ignored: got err=%b v=%b want 1/0", b_err, b_ov); end
        b_sel = 3'b000; b_clr = 1'b0;
        idle_all();
    endtask

    task automatic test_random_b();
        logic [31:0] qd[$];
        int          qi[$];
        int          ch;
        logic [2:0]  exp_ready;
        for (int cyc = 0; cyc < 310; cyc++) begin
            @(negedge clk);
            #1;
            n_vec++; if (b_ov !== (qd.size() > 0) || b_err !== 1'b0) begin
                n_err++; $display("FAIL rand_b_valid: got v=%b err=%b want %b/0", b_ov, b_err, qd.size() > 0); end
            if (qd.size() > 0) begin
                n_vec++; if (b_out !== qd[0] || b_idx !== 2'(qi[0])) begin
                    n_err++; $display("FAIL rand_b_head: got %h/%0d want %h/%0d", b_out, b_idx, qd[0], qi[0]); end
            end
            ch = $urandom_range(0, 2);
            for (int i = 0; i < 3; i++) b_in[i] = $urandom;
            if (cyc < 300) begin
                b_sel = ($urandom % 4 == 0) ? 3'b000 : 3'(1 << ch);
                b_valid = 3'($urandom);
                b_or = ($urandom % 2 != 0);
            end else begin
                b_sel = 3'b000; b_valid = 3'b000; b_or = 1'b1;
            end
            #1;
            exp_ready = (qd.size() < 3) ? b_sel : 3'b000;
            n_vec++; if (b_ready !== exp_ready) begin n_err++; $display("FAIL rand_b_ready: got %b want %b", b_ready, exp_ready); end
            if (qd.size() > 0 && b_or) begin
                void'(qd.pop_front()); void'(qi.pop_front());
            end
            if (|(b_valid & exp_ready)) begin
                qd.push_back(b_in[ch]); qi.push_back(ch);
            end
        end
        n_vec++; if (qd.size() != 0) begin n_err++; $display("FAIL rand_b_drain: got %0d left want 0", qd.size()); end
        idle_all();
    endtask

    task automatic test_random_c();
        logic [31:0] qd[$];
        logic [0:0]  exp_ready;
        for (int cyc = 0; cyc < 205; cyc++) begin
            @(negedge clk);
            #1;
            n_vec++; if (c_ov !== (qd.size() > 0) || c_idx !== 1'b0) begin
                n_err++; $display("FAIL rand_c_valid: got v=%b idx=%0d want %b/0", c_ov, c_idx, qd.size() > 0); end
            if (qd.size() > 0) begin
                n_vec++; if (c_out !== qd[0]) begin n_err++; $display("FAIL rand_c_head: got %h want %h", c_out, qd[0]); end
            end
            c_in[0] = $urandom;
            if (cyc < 200) begin
                c_sel = 1'($urandom); c_valid = 1'($urandom); c_or = ($urandom % 2 != 0);
            end else begin
                c_sel = 1'b0; c_valid = 1'b0; c_or = 1'b1;
            end
            #1;
            exp_ready = (qd.size() < 1) ? c_sel : 1'b0;
            n_vec++; if (c_ready !== exp_ready) begin n_err++; $display("FAIL rand_c_ready: got %b want %b", c_ready, exp_ready); end
            if (qd.size() > 0 && c_or) void'(qd.pop_front());
            if (|(c_valid & exp_ready)) qd.push_back(c_in[0]);
        end
        n_vec++; if (qd.size() != 0) begin n_err++; $display("FAIL rand_c_drain: got %0d left want 0", qd.size()); end
        idle_all();
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a_sel = 8'h20; a_valid = 8'h20; a_in[5] = 32'hCAFE_F00D; a_or = 1'b0;
        @(negedge clk);
        a_sel = 8'h03; a_valid = 8'h00;
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b1 || a_idx !== 3'd5 || a_err !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got v=%b idx=%0d err=%b want 1/5/1", a_ov, a_idx, a_err); end
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if (a_ov !== 1'b0 || a_out !== 32'h0 || a_idx !== 3'd0 || a_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_async: got v=%b out=%h idx=%0d err=%b want 0/0/0/0", a_ov, a_out, a_idx, a_err); end
        @(negedge clk);
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        #1;
        n_vec++; if (a_ov !== 1'b0 || a_err !== 1'b0) begin
            n_err++; $display("FAIL midrst_after: got v=%b err=%b want 0/0", a_ov, a_err); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_push();
        drain_all();
        test_backpressure();
        drain_all();
        test_wrap_stream();
        drain_all();
        test_multi_hot();
        test_zero_sel();
        drain_all();
        test_err_pulse_b();
        drain_all();
        test_random_b();
        test_random_c();
        drain_all();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
